// File: rtl/lfsr_mod_pkg.sv
// Shared types for the LFSR-driven sample modulator.
package lfsr_mod_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    MOD_ASK  = 2'b00,
    MOD_BPSK = 2'b01,
    MOD_PASS = 2'b10,
    MOD_MUTE = 2'b11
  } mod_mode_e;

  // Control half of the stage-1 payload; the sample itself travels next to it
  // so the data width can stay a module parameter.
  typedef struct packed {
    logic      lfsr_b;
    mod_mode_e mode;
  } s1_payload_t;

endpackage

// File: rtl/lfsr_modulator_pipe_stage.sv
// Generic valid/ready register slice with full back-pressure.
module pipe_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // The slice takes new data when empty or when its content leaves this cycle.
  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Load on advance; hold contents while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/lfsr_modulator.sv
// ASK / BPSK / passthrough / mute modulator driven by LFSR_out[0], with a
// two-slice valid/ready pipeline and an LFSR symbol-transition counter.
// Build option: define LFSR_MOD_SAT_EN to saturate BPSK negation of the
// most-negative sample to the most-positive value.
module lfsr_modulator
  import lfsr_mod_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lfsr_bit,
  input  logic [1:0]               mod_sel,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]         sym_cnt
);

  localparam int P1_W = DATA_W + $bits(s1_payload_t);
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  function automatic logic signed [DATA_W-1:0] f_negate(input logic signed [DATA_W-1:0] d);
    logic signed [DATA_W-1:0] n;
    n = -d;
`ifdef LFSR_MOD_SAT_EN
    if (d == MOST_NEG) n = MOST_POS;
`endif
    return n;
  endfunction

  function automatic logic signed [DATA_W-1:0] f_modulate(input logic signed [DATA_W-1:0] d,
                                                          input s1_payload_t c);
    logic signed [DATA_W-1:0] r;
    r = '0;
    case (c.mode)
      MOD_ASK:  r = c.lfsr_b ? d : '0;
      MOD_BPSK: r = c.lfsr_b ? d : f_negate(d);
      MOD_PASS: r = d;
      MOD_MUTE: r = '0;
    endcase
    return r;
  endfunction

  logic                     w_s1_in_ready;
  logic                     w_s2_in_ready;
  logic                     w_s1_valid;
  logic [P1_W-1:0]          w_s1_in;
  logic [P1_W-1:0]          w_s1_out;
  s1_payload_t              w_ctrl_in;
  s1_payload_t              w_ctrl_out;
  logic signed [DATA_W-1:0] w_s1_data;
  logic signed [DATA_W-1:0] w_mod_data;
  logic                     w_accept;
  logic [CNT_W-1:0]         r_sym_cnt;
  logic                     r_last_bit;

  // Bit and mode are captured with the sample so later changes never touch it.
  assign w_ctrl_in = '{lfsr_b: lfsr_bit, mode: mod_mode_e'(mod_sel)};
  assign w_s1_in   = {s_data, w_ctrl_in};
  assign s_ready   = w_s1_in_ready && !rst;
  assign w_accept  = s_valid && s_ready;

  pipe_stage #(.W(P1_W)) u_stage1 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (s_valid),
    .o_ready (w_s1_in_ready),
    .i_data  (w_s1_in),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_in_ready),
    .o_data  (w_s1_out)
  );

  assign {w_s1_data, w_ctrl_out} = w_s1_out;
  assign w_mod_data = f_modulate(w_s1_data, w_ctrl_out);

  pipe_stage #(.W(DATA_W)) u_stage2 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_in_ready),
    .i_data  (w_mod_data),
    .o_valid (m_valid),
    .i_ready (m_ready),
    .o_data  (m_data)
  );

  assign sym_cnt = r_sym_cnt;

  // Count changes of the captured bit; last bit starts at 1 so an initial 0 counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sym_cnt  <= '0;
      r_last_bit <= 1'b1;
    end else if (w_accept) begin
      if (lfsr_bit != r_last_bit) r_sym_cnt <= r_sym_cnt + 1'b1;
      r_last_bit <= lfsr_bit;
    end
  end

endmodule
